// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - looping multi-channel step sequencer with record, pause and memory wipe
module step_sequencer #(
  parameter int PTN_WIDTH   = 2,
  parameter int NUM_STEPS   = 8,
  parameter int STEP_COUNTS = 6000000 - 1,
  localparam int ADDR_WIDTH = $clog2(NUM_STEPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set,
  input  logic [PTN_WIDTH-1:0]  ptn,
  input  logic                  start_stop,
  input  logic                  clear,
  output logic [PTN_WIDTH-1:0]  out,
  output logic [ADDR_WIDTH-1:0] play_step,
  output logic [ADDR_WIDTH-1:0] rec_step,
  output logic                  step_tick,
  output logic                  rec_wrap,
  output logic                  busy
);

  localparam int TIMER_WIDTH = (STEP_COUNTS > 0) ? $clog2(STEP_COUNTS + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(NUM_STEPS - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(STEP_COUNTS);

  typedef enum logic [1:0] {IDLE, PLAY, CLEAR} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [ADDR_WIDTH-1:0]  clear_idx;
  logic [PTN_WIDTH-1:0]   mem [NUM_STEPS];
  logic                   write_en;
  logic                   timer_done;
  logic                   stay_play;

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = CLEAR;
    end else begin
      case (state)
        IDLE:    if (start_stop) next_state = PLAY;
        PLAY:    if (start_stop) next_state = IDLE;
        CLEAR:   if (clear_idx == LAST_ADDR) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // A step only advances if PLAY continues; leaving PLAY on a terminal count swallows the tick.
  always_comb begin
    stay_play  = (state == PLAY) && (next_state == PLAY);
    timer_done = stay_play && (timer == TIMER_MAX);
    write_en   = set && !clear && !start_stop && (state != CLEAR);
    busy       = (state == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      play_step <= '0;
      rec_step  <= '0;
      clear_idx <= '0;
      step_tick <= 1'b0;
      rec_wrap  <= 1'b0;
      out       <= '0;
    end else begin
      state     <= next_state;
      out       <= mem[play_step];
      step_tick <= timer_done;
      rec_wrap  <= write_en && (rec_step == LAST_ADDR);

      if (stay_play) begin
        timer <= timer_done ? '0 : timer + 1'b1;
      end else begin
        timer <= '0;
      end

      if (clear) begin
        play_step <= '0;
        rec_step  <= '0;
        clear_idx <= '0;
      end else begin
        if (timer_done) begin
          play_step <= (play_step == LAST_ADDR) ? '0 : play_step + 1'b1;
        end
        if (write_en) begin
          rec_step <= (rec_step == LAST_ADDR) ? '0 : rec_step + 1'b1;
        end
        if (state == CLEAR) begin
          clear_idx <= (clear_idx == LAST_ADDR) ? '0 : clear_idx + 1'b1;
        end
      end
    end
  end

  // Pattern memory has no reset; a reset mid-wipe leaves the untouched addresses intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clear_idx] <= '0;
      end else if (write_en) begin
        mem[rec_step] <= ptn;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer
module tb_step_sequencer;
  localparam int PW = 2;
  localparam int NS = 4;
  localparam int SC = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, set, start_stop, clear;
  logic [PW-1:0] ptn;
  logic [PW-1:0] out;
  logic [AW-1:0] play_step, rec_step;
  logic          step_tick, rec_wrap, busy;

  step_sequencer #(.PTN_WIDTH(PW), .NUM_STEPS(NS), .STEP_COUNTS(SC)) dut (
    .clk(clk), .rst(rst), .set(set), .ptn(ptn), .start_stop(start_stop), .clear(clear),
    .out(out), .play_step(play_step), .rec_step(rec_step), .step_tick(step_tick),
    .rec_wrap(rec_wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int step; int dat; bit chk_out; int cyc; } exp_t;
  typedef struct { logic [PW-1:0] ptn; int exp_rec; int exp_wrap; } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   mdl[NS];
  int   mrec;
  bit   out_pend = 1'b0;
  int   out_exp;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int step, input int dat, input bit chk, input int c);
    exp_t e;
    e.step = step; e.dat = dat; e.chk_out = chk; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("sb_drained", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    tick();
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      set = 1'b1;
      ptn = vecs[i].ptn;
      tick();
      set = 1'b0;
      mdl[mrec] = int'(vecs[i].ptn);
      mrec = (mrec + 1) % NS;
      check("rec_step", int'(rec_step), vecs[i].exp_rec);
      check("rec_wrap", int'(rec_wrap), vecs[i].exp_wrap);
    end
    tick();
    check("rec_wrap_single", int'(rec_wrap), 0);
  endtask

  // Scoreboard consumer: every step_tick must match a queued step, cycle and next-cycle out.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_pend) begin
      out_pend = 1'b0;
      check("sb_out", int'(out), out_exp);
    end
    if (step_tick) begin
      if (sb.size() == 0) begin
        check("tick_without_expect", int'(step_tick), 0);
      end else begin
        e = sb.pop_front();
        check("sb_step", int'(play_step), e.step);
        check("sb_cycle", cyc, e.cyc);
        if (e.chk_out) begin
          out_pend = 1'b1;
          out_exp  = e.dat;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, c0, c1, c2;
    vecs[0] = '{2'd1, 1, 0}; vecs[1] = '{2'd2, 2, 0};
    vecs[2] = '{2'd3, 3, 0}; vecs[3] = '{2'd0, 0, 1};
    vecs[4] = '{2'd1, 1, 0}; vecs[5] = '{2'd2, 2, 0};
    vecs[6] = '{2'd3, 3, 0}; vecs[7] = '{2'd1, 0, 1};

    rst = 1'b1; set = 1'b0; ptn = '0; start_stop = 1'b0; clear = 1'b0;
    tick(); tick();
    check("rst_out", int'(out), 0);
    check("rst_play_step", int'(play_step), 0);
    check("rst_rec_step", int'(rec_step), 0);
    check("rst_step_tick", int'(step_tick), 0);
    check("rst_rec_wrap", int'(rec_wrap), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Wipe, then record 1,2,3,0
    clear = 1'b1; tick(); clear = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    check("clear_busy_len", n, 4);
    for (int i = 0; i < NS; i++) mdl[i] = 0;
    mrec = 0;
    check("clear_out", int'(out), 0);
    check("clear_play_step", int'(play_step), 0);
    apply_vecs(0, 3);
    check("out_before_play", int'(out), mdl[0]);

    // Play through 1,2,3,0,1 and on to 2
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 6; k++) push(k % NS, mdl[k % NS], 1'b1, c0 + 4 * k);
    wait_sb();

    // Pause mid-period at step 2, then resume
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    repeat (20) tick();
    check("pause_out", int'(out), mdl[2]);
    check("pause_step", int'(play_step), 2);
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    c1 = cyc;
    push(3, mdl[3], 1'b1, c1 + 4);
    push(0, mdl[0], 1'b1, c1 + 8);
    wait_sb();

    // Move rec_step to 1, then collide a write with the read of address 1
    set = 1'b1; ptn = 2'd1; tick(); set = 1'b0;
    mdl[0] = 1; mrec = 1;
    check("rec_step_pre_collide", int'(rec_step), 1);
    push(1, mdl[1], 1'b1, c1 + 12);
    wait_sb();
    check("collide_pre", int'(out), 2);
    push(2, mdl[2], 1'b1, c1 + 16);
    set = 1'b1; ptn = 2'd3; tick(); set = 1'b0;
    mdl[1] = 3; mrec = 2;
    check("collide_old", int'(out), 2);
    check("collide_play_step", int'(play_step), 1);
    check("collide_rec_step", int'(rec_step), 2);
    tick();
    check("collide_new", int'(out), 3);

    // Clear from PLAY on the terminal timer count; set/start_stop during busy are ignored
    repeat (3) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_no_tick", int'(step_tick), 0);
    check("clear_busy", int'(busy), 1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 2) begin set = 1'b1; ptn = 2'd2; start_stop = 1'b1; end
      tick();
      set = 1'b0; start_stop = 1'b0;
    end
    check("clear_play_busy_len", n, 4);
    check("clear_play_step", int'(play_step), 0);
    check("clear_rec_step", int'(rec_step), 0);
    check("clear_play_out", int'(out), 0);
    for (int i = 0; i < NS; i++) mdl[i] = 0;
    mrec = 0;
    repeat (8) tick();
    check("idle_after_clear_step", int'(play_step), 0);
    check("idle_after_clear_rec", int'(rec_step), 0);

    // Reset in the second CLEAR cycle leaves addresses 2..3 intact
    apply_vecs(4, 7);
    clear = 1'b1; tick(); clear = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_clear_busy", int'(busy), 0);
    check("rst_clear_out", int'(out), 0);
    check("rst_clear_step", int'(play_step), 0);
    mdl[0] = 0;
    tick();
    check("rst_clear_out_next", int'(out), mdl[0]);
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    c2 = cyc;
    push(1, 0, 1'b0, c2 + 4);
    push(2, mdl[2], 1'b1, c2 + 8);
    push(3, mdl[3], 1'b1, c2 + 12);
    push(0, mdl[0], 1'b1, c2 + 16);
    wait_sb();
    start_stop = 1'b1; tick(); start_stop = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
